// File: rtl/jtcop_pal_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtcop_pal_dma_pkg
//  Description : Shared constants for the palette copy engine: palette size
//                and the copy state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package jtcop_pal_dma_pkg;

    // Palette RAM word-address width (1k x 16 palette)
    localparam int PAL_AW = 10;

    // Copy engine states, 3-bit encoding
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WAIT_VB = 3'd1;
    localparam logic [2:0] c_ST_REQ     = 3'd2;
    localparam logic [2:0] c_ST_WRITE   = 3'd3;
    localparam logic [2:0] c_ST_SUSPEND = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

endpackage : jtcop_pal_dma_pkg
`default_nettype wire

// File: rtl/jtcop_vb_edge.sv
`default_nettype none
// ============================================================================
//  Module      : jtcop_vb_edge
//  Description : Registers the active-low vertical blank and flags the cycle
//                in which blanking begins. Reusable by any helper that has to
//                synchronise work to the start of a blank.
//  Revision    : 1.0  initial release
// ============================================================================
module jtcop_vb_edge (
    input  logic clk,
    input  logic rst,
    input  logic lvbl_i,      // vertical blank, active low
    output logic fall_o,      // first cycle of a new blank
    output logic blank_o,     // live blank (LVBL low now)
    output logic blank_q_o    // blank as seen one cycle ago
);

    logic lvbl_q;

    // Reset to "in blank" so a blank already running when reset is released
    // never produces a falling edge; work waits for the next full blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvbl_q <= 1'b0;
        end else begin
            lvbl_q <= lvbl_i;
        end
    end

    assign fall_o    = lvbl_q & ~lvbl_i;
    assign blank_o   = ~lvbl_i;
    assign blank_q_o = ~lvbl_q;

endmodule : jtcop_vb_edge
`default_nettype wire

// File: rtl/jtcop_pal_dma.sv
`default_nettype none
// ============================================================================
//  Module      : jtcop_pal_dma
//  Description : Copies a full palette image from a source buffer into the
//                palette RAM during vertical blank, one word per request,
//                yielding the palette write port to CPU accesses. A copy that
//                does not fit in one blank is resumed at the next blank.
//  Revision    : 1.0  initial release
// ============================================================================
module jtcop_pal_dma
    import jtcop_pal_dma_pkg::*;
#(
    parameter int              AW       = PAL_AW,
    parameter int              SRCW     = 22,
    parameter logic [SRCW-1:0] SRC_BASE = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            LVBL,
    input  logic            trig,
    output logic [SRCW-1:0] src_addr,
    output logic            src_cs,
    input  logic            src_ok,
    input  logic [15:0]     src_data,
    output logic [AW-1:0]   pal_addr,
    output logic [15:0]     pal_dout,
    output logic [1:0]      pal_we,
    input  logic            cpu_pal_cs,
    output logic            busy,
    output logic            done
);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [15:0]   dout_q,  dout_d;
    logic          pending_q, pending_d;

    logic w_vb_fall;
    logic w_blank;
    logic w_blank_q;
    logic w_start;
    logic w_wr_go;
    logic w_last;

    jtcop_vb_edge u_vb_edge (
        .clk       (clk),
        .rst       (rst),
        .lvbl_i    (LVBL),
        .fall_o    (w_vb_fall),
        .blank_o   (w_blank),
        .blank_q_o (w_blank_q)
    );

    // A write is granted when the CPU is not on the port and the cycle began
    // inside the blank. Using the registered blank lets the write that is in
    // flight when blank ends complete; the live LVBL then decides whether to
    // fetch the next word or suspend until the next blank.
    assign w_wr_go = (state_q == c_ST_WRITE) && !cpu_pal_cs && w_blank_q;
    assign w_last  = &cnt_q;
    assign w_start = (state_q == c_ST_WAIT_VB) && w_vb_fall;

    // Next-state and datapath decode for the copy sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        // A trigger always (re)arms the request; starting a copy consumes it,
        // so any number of triggers during a copy queue exactly one more.
        pending_d = trig | (pending_q & ~w_start);

        case (state_q)
            c_ST_IDLE: begin
                if (pending_q) begin
                    state_d = c_ST_WAIT_VB;
                end
            end
            c_ST_WAIT_VB: begin
                if (w_vb_fall) begin
                    cnt_d   = '0;
                    state_d = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                // The request is held until the source answers, even if the
                // blank ends meanwhile, so no source access is abandoned.
                if (src_ok) begin
                    dout_d  = src_data;
                    state_d = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                if (w_wr_go) begin
                    if (w_last) begin
                        state_d = c_ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = w_blank ? c_ST_REQ : c_ST_SUSPEND;
                    end
                end
            end
            c_ST_SUSPEND: begin
                if (w_vb_fall) begin
                    state_d = c_ST_REQ;
                end
            end
            c_ST_DONE: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Sequencer state, word counter, write data and pending request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            cnt_q     <= '0;
            dout_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            pending_q <= pending_d;
        end
    end

    // Source address is the base plus the word index, wrapping at 2**SRCW;
    // it only changes in WRITE, so it is stable for the whole request.
    assign src_addr = SRC_BASE + SRCW'(cnt_q);
    assign src_cs   = (state_q == c_ST_REQ);
    assign pal_addr = cnt_q;
    assign pal_dout = dout_q;
    assign pal_we   = {2{w_wr_go}};
    assign busy     = pending_q | (state_q != c_ST_IDLE);
    assign done     = (state_q == c_ST_DONE);

endmodule : jtcop_pal_dma
`default_nettype wire
